// File: rtl/ecc_serial_loader.sv
// Bit-serial operand loader for the ECC point-multiply core: decodes the mode
// preamble, shifts operands in MSB-first and strobes o_load_done when complete.
module ecc_serial_loader #(
  parameter int MAX_BITS = 128,
  parameter int CNT_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_data_valid,
  input  logic                i_mode,
  input  logic                i_a,
  input  logic                i_prime,
  input  logic                i_Px,
  input  logic                i_Py,
  input  logic                i_m,
  input  logic                i_core_busy,
  output logic [1:0]          o_mode,
  output logic [MAX_BITS-1:0] o_a,
  output logic [MAX_BITS-1:0] o_prime,
  output logic [MAX_BITS-1:0] o_Px,
  output logic [MAX_BITS-1:0] o_Py,
  output logic [MAX_BITS-1:0] o_m,
  output logic                o_full_load,
  output logic                o_load_done,
  output logic                o_busy
);

  typedef enum logic [2:0] {IDLE, MODE_HI, MODE_LO, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic             configured;
  logic             full_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Index of the last bit to shift for a given mode (bits(mode) - 1).
  function automatic logic [CNT_W-1:0] last_bit(input logic [1:0] mode);
    case (mode)
      2'b00:   last_bit = CNT_W'(15);
      2'b01:   last_bit = CNT_W'(31);
      2'b10:   last_bit = CNT_W'(63);
      default: last_bit = CNT_W'(127);
    endcase
  endfunction

  assign accept = (state == IDLE) && i_data_valid && !i_core_busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first; a missing branch
  // assignment would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    o_busy      = 1'b0;
    o_load_done = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = configured ? SHIFT : MODE_HI;
      MODE_HI: begin o_busy = 1'b1; state_next = MODE_LO; end
      MODE_LO: begin o_busy = 1'b1; state_next = SHIFT; end
      SHIFT: begin
        o_busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        o_load_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the operand registers are plain flops read by the core, not a
  // memory, so they take the reset and come up as a defined all-zero state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      configured  <= 1'b0;
      full_q      <= 1'b0;
      cnt         <= '0;
      o_mode      <= 2'b00;
      o_full_load <= 1'b0;
      o_a         <= '0;
      o_prime     <= '0;
      o_Px        <= '0;
      o_Py        <= '0;
      o_m         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_Px <= '0;
            o_Py <= '0;
            if (!configured) begin
              full_q  <= 1'b1;
              o_a     <= '0;
              o_prime <= '0;
              o_m     <= '0;
            end else begin
              full_q <= 1'b0;
              cnt    <= last_bit(o_mode);
            end
          end
        end
        MODE_HI: o_mode[1] <= i_mode;
        MODE_LO: begin
          o_mode[0] <= i_mode;
          cnt       <= last_bit({o_mode[1], i_mode});
        end
        SHIFT: begin
          o_Px <= {o_Px[MAX_BITS-2:0], i_Px};
          o_Py <= {o_Py[MAX_BITS-2:0], i_Py};
          if (full_q) begin
            o_a     <= {o_a[MAX_BITS-2:0], i_a};
            o_prime <= {o_prime[MAX_BITS-2:0], i_prime};
            o_m     <= {o_m[MAX_BITS-2:0], i_m};
          end
          if (cnt == '0) begin
            // Published together with the entry into DONE so it is valid
            // in the same cycle as o_load_done.
            o_full_load <= full_q;
            configured  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_serial_loader.sv
// Self-checking bench for ecc_serial_loader: directed and randomized loads
// compared against a value-level model of the loaded operands.
module tb_ecc_serial_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_data_valid = 1'b0;
  logic         i_mode = 1'b0;
  logic         i_a = 1'b0, i_prime = 1'b0, i_Px = 1'b0, i_Py = 1'b0, i_m = 1'b0;
  logic         i_core_busy = 1'b0;
  logic [1:0]   o_mode;
  logic [127:0] o_a, o_prime, o_Px, o_Py, o_m;
  logic         o_full_load, o_load_done, o_busy;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  // Model of what the core should see after the most recent load.
  bit           cfg;
  logic [1:0]   exp_mode;
  bit           exp_full;
  logic [127:0] ea, ep, ex, ey, em;

  ecc_serial_loader #(.MAX_BITS(128), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .i_data_valid(i_data_valid), .i_mode(i_mode),
    .i_a(i_a), .i_prime(i_prime), .i_Px(i_Px), .i_Py(i_Py), .i_m(i_m),
    .i_core_busy(i_core_busy), .o_mode(o_mode), .o_a(o_a), .o_prime(o_prime),
    .o_Px(o_Px), .o_Py(o_Py), .o_m(o_m), .o_full_load(o_full_load),
    .o_load_done(o_load_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_load_done === 1'b1) done_pulses++;

  function automatic logic [127:0] mask_bits(input int n);
    logic [127:0] one = 128'd1;
    return (n >= 128) ? {128{1'b1}} : ((one << n) - 128'd1);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    cfg = 0; exp_mode = 2'b00; exp_full = 0;
    ea = '0; ep = '0; ex = '0; ey = '0; em = '0;
  endtask

  task automatic drive_idle_pins();
    i_data_valid = 1'b0;
    i_mode = 1'bx;
    {i_a, i_prime, i_Px, i_Py, i_m} = 5'bxxxxx;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle_pins();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Drives one complete load; whether the preamble is sent follows the
  // model's configured flag. lat = clock edges after the accepting edge
  // until o_load_done is seen. stray_at pulses valid during that data bit.
  task automatic do_load(input logic [127:0] a, p, x, y, m,
                         input logic [1:0] mode, input int stray_at,
                         output int lat);
    bit full;
    int n;
    full = !cfg;
    n = 16 << (full ? mode : exp_mode);
    @(negedge clk);
    i_data_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    i_data_valid = 1'b0;
    if (full) begin
      i_mode = mode[1];
      @(posedge clk); lat++; @(negedge clk);
      i_mode = mode[0];
      @(posedge clk); lat++; @(negedge clk);
    end
    i_mode = 1'bx;
    for (int i = n - 1; i >= 0; i--) begin
      i_a = a[i]; i_prime = p[i]; i_Px = x[i]; i_Py = y[i]; i_m = m[i];
      i_data_valid = (i == stray_at);
      @(posedge clk); lat++; @(negedge clk);
    end
    drive_idle_pins();
    while (o_load_done !== 1'b1 && lat < n + 8) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (full) begin
      cfg = 1; exp_mode = mode; exp_full = 1;
      ea = a & mask_bits(n); ep = p & mask_bits(n); em = m & mask_bits(n);
    end else begin
      exp_full = 0;
    end
    ex = x & mask_bits(n);
    ey = y & mask_bits(n);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({o_mode, o_full_load, o_load_done, o_busy} !== 5'b0 ||
        {o_a, o_prime, o_Px, o_Py, o_m} !== 640'b0) begin
      failures++;
      $display("FAIL reset_outputs mode=%b full=%b done=%b busy=%b a=%h", o_mode, o_full_load, o_load_done, o_busy, o_a);
    end
  endtask

  task automatic test_full16();
    int lat, p0;
    p0 = done_pulses;
    do_load(128'h0003, 128'hFFF1, 128'h1234, 128'hABCD, 128'h00FF, 2'b00, -1, lat);
    checks++;
    if (lat !== 18) begin failures++; $display("FAIL full16_latency got=%0d exp=18", lat); end
    checks++;
    if ({o_mode, o_full_load} !== 3'b001) begin
      failures++; $display("FAIL full16_mode_flag got=%b%b exp=001", o_mode, o_full_load);
    end
    checks++;
    if ({o_a, o_prime, o_Px, o_Py, o_m} !== {ea, ep, ex, ey, em}) begin
      failures++;
      $display("FAIL full16_operands got=%h exp=%h", {o_a[15:0], o_prime[15:0], o_Px[15:0], o_Py[15:0], o_m[15:0]}, {ea[15:0], ep[15:0], ex[15:0], ey[15:0], em[15:0]});
    end
    checks++;
    if ($isunknown({o_a, o_prime, o_Px, o_Py, o_m, o_mode}) !== 1'b0) begin
      failures++; $display("FAIL full16_no_x got=unknown exp=known");
    end
    @(negedge clk);
    checks++;
    if (done_pulses - p0 !== 1) begin failures++; $display("FAIL full16_pulses got=%0d exp=1", done_pulses - p0); end
  endtask

  task automatic test_busy_refused();
    logic [127:0] px_before;
    int p0;
    px_before = o_Px;
    p0 = done_pulses;
    @(negedge clk);
    i_core_busy = 1'b1;
    i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL busy_refused_busy got=%b exp=0", o_busy); end
    repeat (20) @(negedge clk);
    checks++;
    if (done_pulses !== p0 || o_Px !== px_before) begin
      failures++; $display("FAIL busy_refused_state pulses=%0d exp=%0d px=%h", done_pulses - p0, 0, o_Px);
    end
    i_core_busy = 1'b0;
  endtask

  task automatic test_point_reload();
    int lat, p0;
    p0 = done_pulses;
    do_load(rand128(), rand128(), 128'h5555, 128'hAAAA, rand128(), 2'b11, 7, lat);
    checks++;
    if (lat !== 16) begin failures++; $display("FAIL point_latency got=%0d exp=16", lat); end
    checks++;
    if (o_full_load !== 1'b0) begin failures++; $display("FAIL point_full_flag got=%b exp=0", o_full_load); end
    checks++;
    if ({o_Px, o_Py} !== {128'h5555, 128'hAAAA}) begin
      failures++; $display("FAIL point_xy got=%h/%h exp=5555/aaaa", o_Px, o_Py);
    end
    checks++;
    if ({o_a, o_prime, o_m, o_mode} !== {ea, ep, em, exp_mode}) begin
      failures++; $display("FAIL point_held got a=%h p=%h m=%h exp a=%h p=%h m=%h", o_a, o_prime, o_m, ea, ep, em);
    end
    @(negedge clk);
    checks++;
    if (done_pulses - p0 !== 1) begin failures++; $display("FAIL point_pulses got=%0d exp=1", done_pulses - p0); end
  endtask

  task automatic test_stray_in_done();
    int lat, p0;
    do_load(rand128(), rand128(), rand128(), rand128(), rand128(), 2'b00, -1, lat);
    p0 = done_pulses;
    i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL stray_done_busy got=%b exp=0", o_busy); end
    repeat (20) @(negedge clk);
    checks++;
    if (done_pulses - p0 !== 1 || {o_Px, o_Py} !== {ex, ey}) begin
      failures++; $display("FAIL stray_done_ignored pulses=%0d exp=1 px=%h exp=%h", done_pulses - p0, o_Px, ex);
    end
  endtask

  task automatic test_full128();
    int lat;
    apply_reset();
    do_load({128{1'b1}}, {128{1'b1}}, {128{1'b1}}, {128{1'b1}},
            {1'b1, 126'b0, 1'b1}, 2'b11, 60, lat);
    checks++;
    if (lat !== 130) begin failures++; $display("FAIL full128_latency got=%0d exp=130", lat); end
    checks++;
    if ({o_a, o_prime, o_Px, o_Py, o_m, o_mode, o_full_load} !== {ea, ep, ex, ey, em, 2'b11, 1'b1}) begin
      failures++; $display("FAIL full128_operands got a=%h m=%h mode=%b exp m=%h", o_a, o_m, o_mode, em);
    end
  endtask

  task automatic test_reset_midload();
    int lat, p0;
    apply_reset();
    p0 = done_pulses;
    @(negedge clk);
    i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
    i_mode = 1'b0;
    @(negedge clk);
    i_mode = 1'b1;
    @(negedge clk);
    i_mode = 1'bx;
    for (int i = 0; i < 5; i++) begin
      {i_a, i_prime, i_Px, i_Py, i_m} = 5'($urandom());
      @(negedge clk);
    end
    rst = 1'b1;
    drive_idle_pins();
    #1;
    checks++;
    if ({o_mode, o_full_load, o_load_done, o_busy} !== 5'b0 ||
        {o_a, o_prime, o_Px, o_Py, o_m} !== 640'b0) begin
      failures++; $display("FAIL midload_reset_outputs mode=%b busy=%b done=%b", o_mode, o_busy, o_load_done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (40) @(negedge clk);
    checks++;
    if (done_pulses !== p0) begin failures++; $display("FAIL midload_no_done got=%0d exp=0", done_pulses - p0); end
    do_load(rand128(), rand128(), rand128(), rand128(), rand128(), 2'b01, -1, lat);
    checks++;
    if (lat !== 34 || {o_mode, o_full_load} !== 3'b011) begin
      failures++; $display("FAIL midload_reload_latency got=%0d mode=%b full=%b exp=34 01 1", lat, o_mode, o_full_load);
    end
    checks++;
    if ({o_a, o_prime, o_Px, o_Py, o_m} !== {ea, ep, ex, ey, em}) begin
      failures++; $display("FAIL midload_reload_operands got a=%h px=%h exp a=%h px=%h", o_a, o_Px, ea, ex);
    end
  endtask

  task automatic test_random();
    int lat, n;
    logic [1:0] md;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      md = 2'($urandom_range(0, 3));
      for (int ld = 0; ld < 3; ld++) begin
        n = 16 << md;
        do_load(rand128(), rand128(), rand128(), rand128(), rand128(), md,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1, lat);
        checks++;
        if (lat !== ((ld == 0) ? n + 2 : n) || o_full_load !== (ld == 0) || o_mode !== md) begin
          failures++; $display("FAIL random_ctrl it=%0d ld=%0d lat=%0d full=%b mode=%b exp_n=%0d", it, ld, lat, o_full_load, o_mode, n);
        end
        checks++;
        if ({o_a, o_prime, o_Px, o_Py, o_m} !== {ea, ep, ex, ey, em}) begin
          failures++; $display("FAIL random_operands it=%0d ld=%0d px=%h exp=%h m=%h exp=%h", it, ld, o_Px, ex, o_m, em);
        end
      end
    end
  endtask

  initial begin
    drive_idle_pins();
    model_clear();
    test_reset();
    test_full16();
    test_busy_refused();
    test_point_reload();
    test_stray_in_done();
    test_full128();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_serial_loader.md
Name: ecc_serial_loader

Overview:
- Bit-serial input front end of the ECC scalar-multiplication wrapper; sits directly upstream of the point-multiply core.
- Decodes the start/mode preamble and shifts in MSB-first serial operands (a, prime, Px, Py, m) or a point-only reload (Px, Py).
- Presents right-aligned, zero-extended parallel operands and pulses a load-complete strobe to the core.

Parameters:
- MAX_BITS, 128, width of every parallel operand register; largest supported field size.
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W >= MAX_BITS.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_data_valid  input  1  start strobe, one cycle
- i_mode  input  1  serial mode bits; don't-care outside preamble (X tolerated)
- i_a  input  1  serial curve coefficient a
- i_prime  input  1  serial field prime
- i_Px  input  1  serial point x
- i_Py  input  1  serial point y
- i_m  input  1  serial scalar m
- i_core_busy  input  1  core computing; new starts refused while high
- o_mode  output  2  latched mode: 00=16, 01=32, 10=64, 11=128 bits
- o_a, o_prime, o_Px, o_Py, o_m  output  MAX_BITS each  parallel operands, right-aligned
- o_full_load  output  1  1 = last load was full (mode + all operands), 0 = point-only
- o_load_done  output  1  one-cycle pulse, operands valid and stable
- o_busy  output  1  high from accepted start through last shifted bit

Behaviour:
- Reset: all outputs 0, state IDLE, configured flag 0, counter 0. Reset mid-load aborts immediately; no o_load_done.
- States: IDLE, MODE_HI, MODE_LO, SHIFT, DONE.
- IDLE: i_data_valid=1 and i_core_busy=0 is accepted.
  - configured=0: go to MODE_HI; clear o_a, o_prime, o_Px, o_Py, o_m.
  - configured=1: go to SHIFT; clear only o_Px, o_Py; counter = bits(o_mode)-1.
  - Valid while i_core_busy=1 is dropped, with no state change.
- MODE_HI: o_mode[1] <= i_mode; go to MODE_LO.
- MODE_LO: o_mode[0] <= i_mode; counter = bits({o_mode[1], i_mode})-1; go to SHIFT.
- SHIFT: one bit per cycle, reg <= {reg[MAX_BITS-2:0], in}.
  - Full load shifts all five operands; point-only load shifts Px and Py only. o_a, o_prime, o_m hold.
  - When counter = 0, go to DONE; otherwise decrement.
  - Exactly bits(mode) cycles. Because of the clear at start, the result is zero-extended above bit bits-1.
- DONE: o_load_done=1 for exactly this cycle. o_full_load reflects this load. Set configured=1. Return to IDLE.
- o_busy=1 in MODE_HI, MODE_LO, SHIFT; 0 in IDLE and DONE.
- Latency, full load: valid accepted at edge T; mode bits at T+1, T+2; data at T+3..T+2+N; o_load_done high in cycle T+3+N.
- Latency, point-only load: data at T+1..T+N; o_load_done high in cycle T+1+N.
- i_data_valid outside IDLE is ignored, including during SHIFT and DONE.
- i_mode and data pins are sampled only in their own states; X elsewhere must not propagate.
- Operand outputs hold between loads. The core may read them any time after o_load_done.
- configured is cleared only by rst. Each new pattern requires a reset.

Test Plan:
- Full 16-bit load:
  - Stimulus: valid, mode 0,0, then a=16'h0003, prime=16'hFFF1, Px=16'h1234, Py=16'hABCD, m=16'h00FF MSB-first.
  - Required: o_load_done in cycle T+19; o_mode=00; o_full_load=1; outputs equal the values, upper 112 bits 0.
- Point-only reload after the above:
  - Stimulus: valid, then Px=16'h5555, Py=16'hAAAA.
  - Required: o_load_done at T+17; o_full_load=0; o_Px=0x5555, o_Py=0xAAAA; o_a, o_prime, o_m unchanged.
- Full 128-bit load (mode 1,1), all operands 128'hFFFF...FFFF except m=128'h8000...0001:
  - Required: o_load_done at T+131; exact 128-bit match.
- Busy and stray starts:
  - Valid with i_core_busy=1 -> no state change.
  - Valid pulse mid-SHIFT -> ignored; the load completes with correct values and a single o_load_done.
- Reset mid-load:
  - Stimulus: assert rst after 5 data bits of a 32-bit load.
  - Required: all outputs 0, no o_load_done. Next valid performs a full load with mode (configured cleared).
- X tolerance: i_mode=X during SHIFT and i_Px=X in IDLE -> no X on any output after o_load_done.
